hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Multi-cycle unsigned multiply/divide engine that owns the architectural HI/LO registers of the MIPS-lite core. It executes MULTU and DIVU iteratively, one bit per cycle, and executes MTHI and MTLO in a single cycle. It raises busy so the decode/hazard logic stalls any later HI/LO-touching instruction. It sits in the execute stage beside the main ALU and is driven by the ALU control decode.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; also the iteration count for MULTU/DIVU.

Ports:
clk  input  1  core clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  an operation is issued this cycle
op  input  3  0=NONE, 1=MULTU, 2=DIVU, 3=MTHI, 4=MTLO; 5-7 are reserved and treated as NONE
src_a  input  DATA_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
src_b  input  DATA_WIDTH  rt value (multiplier / divisor)
busy  output  1  a MULTU/DIVU is in progress (registered)
done  output  1  one-cycle pulse: MULTU/DIVU result has just been committed to HI/LO
div_by_zero  output  1  one-cycle pulse coincident with done when the DIVU divisor was 0
hi  output  DATA_WIDTH  architectural HI (registered; feeds MFHI)
lo  output  DATA_WIDTH  architectural LO (registered; feeds MFLO)

Behaviour:
- Reset (synchronous, rst=1 at an edge) forces these values, overriding every other input including one in-flight: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, MUL, DIV, FINISH.
- Accept rule: an op is accepted only when op_valid=1 and state=IDLE. When op_valid=1 and busy=1, the op is ignored with no side effects; the pipeline must stall instead. An assertion in the bench flags this.
- MTHI/MTLO (accepted, IDLE): hi or lo <= src_a at that edge. The new value is visible the next cycle. busy and done stay 0.
- MULTU accepted at the edge ending cycle T:
  - latch src_a and src_b into working registers; clear the 2*DATA_WIDTH accumulator; state=MUL; counter=0.
  - each MUL cycle: shift-add one multiplier bit, LSB first; counter+1.
  - after DATA_WIDTH iterations: state=FINISH.
- DIVU accepted at T: restoring division, one quotient bit per cycle, MSB first. Each cycle: remainder={remainder,next dividend bit}; if remainder>=divisor, subtract and set the quotient bit to 1, else set it to 0.
- Timing: busy=1 in cycles T+1 .. T+DATA_WIDTH (32 cycles at default). At the edge ending cycle T+DATA_WIDTH, FINISH commits:
  - MULTU: hi=product[2W-1:W], lo=product[W-1:0].
  - DIVU: lo=quotient, hi=remainder.
- In cycle T+DATA_WIDTH+1: busy=0, done=1, new hi/lo visible, state=IDLE. A new op may be accepted in this same cycle.
- hi/lo hold their old values throughout a MUL/DIV; only working registers change.
- Divide by zero: no special datapath. The restoring algorithm naturally yields lo=all ones and hi=dividend. div_by_zero=1 together with done.
- Arithmetic is unsigned throughout; the product is the full 2*DATA_WIDTH bits with no truncation.
- Operands are sampled only at acceptance; later changes to src_a/src_b are ignored.
- op=NONE or a reserved value with op_valid=1 in IDLE: no effect.

Test Plan:
1. Reset, then MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> busy high for exactly 32 cycles; in cycle T+33 done=1, hi=0xFFFFFFFE, lo=0x00000001.
2. DIVU src_a=100, src_b=7 -> after 32 busy cycles, lo=14, hi=2, done=1, div_by_zero=0.
3. DIVU src_a=0x00001234, src_b=0 -> lo=0xFFFFFFFF, hi=0x00001234; done and div_by_zero both pulse in the same single cycle.
4. MTHI 0xDEADBEEF then MTLO 0x0000CAFE on back-to-back cycles -> hi=0xDEADBEEF, lo=0x0000CAFE one cycle after each; busy and done never assert.
5. MULTU 3*5 followed by MTLO 0x77 issued at T+5 (while busy) -> MTLO ignored; final lo=15, hi=0. A MULTU 2*2 issued in the done cycle is accepted; its result is lo=4 after 32 more busy cycles.
6. Load hi/lo with MTHI/MTLO, start DIVU, assert rst at T+10 -> at the next edge busy=0 and hi=lo=0; no done pulse ever appears for the aborted op.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative unsigned MULTU/DIVU engine that owns the architectural HI/LO registers.
// MTHI/MTLO complete in one cycle; MULTU/DIVU take DATA_WIDTH busy cycles, one bit per cycle.
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 2);

    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] iter_cnt;
    // MUL: work_hi = partial product high, work_lo = multiplier shifting into product low.
    // DIV: work_hi = partial remainder, work_lo = dividend shifting into quotient.
    logic [W-1:0]  work_hi, work_lo, operand;
    logic          op_is_div, divisor_zero;
    logic [W:0]    mul_sum, div_shift;
    logic          div_ge;
    logic [W-1:0]  mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;
    logic          accept;

    always_comb begin
        mul_sum     = {1'b0, work_hi} + {1'b0, {W{work_lo[0]}} & operand};
        mul_hi_nxt  = mul_sum[W:1];
        mul_lo_nxt  = {mul_sum[0], work_lo[W-1:1]};
        div_shift   = {work_hi, work_lo[W-1]};
        div_ge      = div_shift >= {1'b0, operand};
        // When div_ge holds the true difference is below the divisor, so W bits suffice.
        div_rem_nxt = div_ge ? (div_shift[W-1:0] - operand) : div_shift[W-1:0];
        div_quo_nxt = {work_lo[W-2:0], div_ge};
    end

    assign accept = (state == S_IDLE) && op_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && op == OP_MULTU)     state_nxt = S_MUL;
                else if (accept && op == OP_DIVU) state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (iter_cnt == LAST_ITER) state_nxt = S_FINISH;
            S_FINISH:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            iter_cnt     <= '0;
            work_hi      <= '0;
            work_lo      <= '0;
            operand      <= '0;
            op_is_div    <= 1'b0;
            divisor_zero <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != S_IDLE);
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULTU: begin
                                operand   <= src_a;
                                work_lo   <= src_b;
                                work_hi   <= '0;
                                iter_cnt  <= '0;
                                op_is_div <= 1'b0;
                            end
                            OP_DIVU: begin
                                operand      <= src_b;
                                work_lo      <= src_a;
                                work_hi      <= '0;
                                iter_cnt     <= '0;
                                op_is_div    <= 1'b1;
                                divisor_zero <= (src_b == '0);
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    work_hi  <= mul_hi_nxt;
                    work_lo  <= mul_lo_nxt;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                S_DIV: begin
                    work_hi  <= div_rem_nxt;
                    work_lo  <= div_quo_nxt;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                S_FINISH: begin
                    // Final iteration is folded into the commit so busy spans exactly W cycles.
                    if (op_is_div) begin
                        hi <= div_rem_nxt;
                        lo <= div_quo_nxt;
                    end else begin
                        hi <= mul_hi_nxt;
                        lo <= mul_lo_nxt;
                    end
                    done        <= 1'b1;
                    div_by_zero <= op_is_div && divisor_zero;
                    iter_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: reset, MULTU/DIVU results and timing, MTHI/MTLO,
// ignored issue while busy, back-to-back accept in the done cycle, abort by reset.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int stall_issues = 0;

    int busy_cnt;
    bit done_early, hilo_moved;

    hilo_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Flags any issue attempt while the unit is busy; the decode stage must stall instead.
    always @(posedge clk) begin
        if (!rst && op_valid && busy) stall_issues++;
    end

    // Issue an op in the current cycle (called at a negedge), then measure the busy window.
    // Returns in the first non-busy cycle, i.e. the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0; src_a = ~a; src_b = ~b;
        busy_cnt = 0; done_early = 0; hilo_moved = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            busy_cnt++;
            if (done) done_early = 1;
            if (hi !== hi0 || lo !== lo0) hilo_moved = 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset: busy/done/dbz=%b%b%b hi=%h lo=%h, want 000 0 0", busy, done, div_by_zero, hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy_cnt !== 32) begin errors++; $display("FAIL mul_busy_len: got %0d want 32", busy_cnt); end
        checks++;
        if (done_early || hilo_moved) begin
            errors++; $display("FAIL mul_hold: done_early=%0d hilo_moved=%0d want 0 0", done_early, hilo_moved);
        end
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL mul_done: done=%b dbz=%b want 1 0", done, div_by_zero);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL mul_result: hi=%h lo=%h want fffffffe 00000001", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_divu();
        run_op(3'd2, 32'd100, 32'd7);
        checks++;
        if (busy_cnt !== 32) begin errors++; $display("FAIL div_busy_len: got %0d want 32", busy_cnt); end
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL div_result: done=%b dbz=%b lo=%0d hi=%0d want 1 0 14 2", done, div_by_zero, lo, hi);
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        run_op(3'd2, 32'h0000_1234, 32'd0);
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL dbz_pulse: done=%b dbz=%b want 1 1", done, div_by_zero);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin
            errors++; $display("FAIL dbz_result: lo=%h hi=%h want ffffffff 00001234", lo, hi);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL dbz_single: done=%b dbz=%b want 0 0", done, div_by_zero);
        end
    endtask

    task automatic test_mthi_mtlo();
        op_valid = 1'b1; op = 3'd3; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mthi: hi=%h busy=%b done=%b want deadbeef 0 0", hi, busy, done);
        end
        op = 3'd4; src_a = 32'h0000_CAFE;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        checks++;
        if (lo !== 32'h0000_CAFE || hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h hi=%h busy=%b done=%b want 0000cafe deadbeef 0 0", lo, hi, busy, done);
        end
    endtask

    task automatic test_reserved_ops();
        op_valid = 1'b1; src_a = 32'h1111_2222; src_b = 32'h3;
        op = 3'd0; @(negedge clk);
        op = 3'd5; @(negedge clk);
        op = 3'd7; @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hDEAD_BEEF || lo !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL reserved_op: busy=%b done=%b hi=%h lo=%h want 0 0 deadbeef 0000cafe", busy, done, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int stall0;
        int n;
        stall0 = stall_issues;
        op_valid = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        repeat (4) @(negedge clk);
        op_valid = 1'b1; op = 3'd4; src_a = 32'h77;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0; src_a = '0;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        checks++;
        if (stall_issues - stall0 !== 1) begin
            errors++; $display("FAIL stall_flag: flagged=%0d want 1", stall_issues - stall0);
        end
        checks++;
        if (done !== 1'b1 || lo !== 32'd15 || hi !== 32'd0) begin
            errors++; $display("FAIL mul_ignore_mtlo: done=%b lo=%h hi=%h want 1 0000000f 0", done, lo, hi);
        end
        run_op(3'd1, 32'd2, 32'd2);
        checks++;
        if (busy_cnt !== 32 || done !== 1'b1 || lo !== 32'd4 || hi !== 32'd0) begin
            errors++;
            $display("FAIL accept_in_done: busy_len=%0d done=%b lo=%h hi=%h want 32 1 4 0", busy_cnt, done, lo, hi);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int done_seen;
        op_valid = 1'b1; op = 3'd3; src_a = 32'h0000_0011; @(negedge clk);
        op = 3'd4; src_a = 32'h0000_0022; @(negedge clk);
        op = 3'd2; src_a = 32'd1000; src_b = 32'd3; @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL div_inflight: busy=%b hi=%h lo=%h want 1 11 22", busy, hi, lo);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_reset: busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi, lo, done);
        end
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: active cycles=%0d want 0", done_seen); end
        run_op(3'd1, 32'd6, 32'd7);
        checks++;
        if (busy_cnt !== 32 || lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL post_abort_mul: busy_len=%0d lo=%h hi=%h want 32 2a 0", busy_cnt, lo, hi);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_divu();
        test_div_by_zero();
        test_mthi_mtlo();
        test_reserved_ops();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
